// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: round-robin scan of a 4:1 mux into a 4-bit frame with a valid pulse
module mux4_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_y,
  output logic       s0,
  output logic       s1,
  output logic [3:0] frame,
  output logic       valid,
  output logic       busy
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [1:0] ch;
  logic [CW-1:0] cnt;
  logic [2:0] shadow;
  assign s0 = ch[0];
  assign s1 = ch[1];
  // scan sequencer: dwell on each channel, capture y on the last dwell edge, publish the frame after channel 3
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= 2'd0;
      cnt <= '0;
      shadow <= 3'b000;
      frame <= 4'b0000;
      valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= SCAN;
          busy <= 1'b1;
          ch <= 2'd0;
          cnt <= '0;
        end
      end else if (cnt == CW'(DWELL - 1)) begin
        cnt <= '0;
        if (ch != 2'd3) begin
          shadow[ch] <= mux_y;
          ch <= ch + 2'd1;
        end else begin
          frame <= {mux_y, shadow};
          valid <= 1'b1;
          ch <= 2'd0;
          if (!cont) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: table vectors plus scoreboarded frames for DWELL=2 and DWELL=1 instances
module tb_mux4_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b1, cont2 = 1'b0, start1 = 1'b1, cont1 = 1'b0;
  logic [3:0] data2 = 4'b0000, data1 = 4'b0000;
  logic s0_2, s1_2, valid2, busy2, s0_1, s1_1, valid1, busy1;
  logic [3:0] frame2, frame1, e2, e1;
  logic y2, y1;
  logic [3:0] q2[$];
  logic [3:0] q1[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct { logic [3:0] data; logic [3:0] exp; } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign y2 = data2[{s1_2, s0_2}];
  assign y1 = data1[{s1_1, s0_1}];

  mux4_scan_ctrl #(.DWELL(2), .CW(4)) d2 (
    .clk(clk), .rst(rst), .start(start2), .cont(cont2), .mux_y(y2),
    .s0(s0_2), .s1(s1_2), .frame(frame2), .valid(valid2), .busy(busy2));
  mux4_scan_ctrl #(.DWELL(1), .CW(4)) d1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_y(y1),
    .s0(s0_1), .s1(s1_1), .frame(frame1), .valid(valid1), .busy(busy1));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid2) begin
      if (q2.size() == 0) check("unexpected_valid2", 8'd1, 8'd0);
      else begin
        e2 = q2.pop_front();
        check("sb_frame2", {4'd0, frame2}, {4'd0, e2});
      end
    end
    if (valid1) begin
      if (q1.size() == 0) check("unexpected_valid1", 8'd1, 8'd0);
      else begin
        e1 = q1.pop_front();
        check("sb_frame1", {4'd0, frame1}, {4'd0, e1});
      end
    end
  end

  task automatic wait_v(input bit one, output int at);
    at = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (one ? valid1 : valid2) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("valid_timeout", 8'd0, 8'd1);
  endtask

  task automatic run_scan2(input logic [3:0] data, input logic [3:0] exp, input bit mid);
    data2 = data;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    q2.push_back(exp);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mid && k == 2) start2 = 1'b1;
      if (mid && k == 4) start2 = 1'b0;
      check("sel", {6'd0, s1_2, s0_2}, 8'(k / 2));
      check("busy_scan", {7'd0, busy2}, 8'd1);
      check("valid_early", {7'd0, valid2}, 8'd0);
    end
    @(negedge clk);
    check("valid_pulse", {7'd0, valid2}, 8'd1);
    check("frame", {4'd0, frame2}, {4'd0, exp});
    check("busy_done", {7'd0, busy2}, 8'd0);
    check("sel_idle", {6'd0, s1_2, s0_2}, 8'd0);
    @(negedge clk);
    check("valid_once", {7'd0, valid2}, 8'd0);
    check("frame_hold", {4'd0, frame2}, {4'd0, exp});
  endtask

  initial begin
    int t1, t2, tp;
    vecs[0] = '{4'b1101, 4'b1101};
    vecs[1] = '{4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 4'b1111};
    vecs[3] = '{4'b0110, 4'b0110};
    vecs[4] = '{4'b1010, 4'b1010};
    repeat (3) begin
      @(negedge clk);
      check("rst2", {s1_2, s0_2, frame2, valid2, busy2}, 8'd0);
      check("rst1", {s1_1, s0_1, frame1, valid1, busy1}, 8'd0);
    end
    rst = 1'b0;
    start2 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    check("post_rst2", {s1_2, s0_2, frame2, valid2, busy2}, 8'd0);
    check("post_rst1", {s1_1, s0_1, frame1, valid1, busy1}, 8'd0);
    foreach (vecs[i]) run_scan2(vecs[i].data, vecs[i].exp, 1'b0);
    data2 = 4'b1101;
    cont2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    q2.push_back(4'b1101);
    wait_v(1'b0, t1);
    data2 = 4'b0110;
    q2.push_back(4'b0110);
    cont2 = 1'b0;
    check("cont_busy", {7'd0, busy2}, 8'd1);
    wait_v(1'b0, t2);
    check("cont_spacing", 8'(t2 - t1), 8'd8);
    @(negedge clk);
    check("cont_idle", {7'd0, busy2}, 8'd0);
    run_scan2(4'b1011, 4'b1011, 1'b1);
    repeat (4) @(negedge clk);
    data2 = 4'b1111;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_sel", {6'd0, s1_2, s0_2}, 8'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst", {s1_2, s0_2, frame2, valid2, busy2}, 8'd0);
    @(negedge clk);
    check("midrst_novalid", {7'd0, valid2}, 8'd0);
    run_scan2(4'b0101, 4'b0101, 1'b0);
    data1 = 4'($urandom);
    cont1 = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    q1.push_back(data1);
    tp = -1;
    for (int i = 0; i < 16; i++) begin
      wait_v(1'b1, t1);
      if (i > 0) check("d1_spacing", 8'(t1 - tp), 8'd4);
      tp = t1;
      if (i < 15) begin
        data1 = 4'($urandom);
        q1.push_back(data1);
      end
      if (i == 14) cont1 = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("d1_idle", {7'd0, busy1}, 8'd0);
    check("q2_drained", 8'(q2.size()), 8'd0);
    check("q1_drained", 8'(q1.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
